// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared constants, state encoding and sizing helper for the rotary decoder
package rotary_pkg;

  localparam logic DIR_CW         = 1'b1;
  localparam logic DIR_CCW        = 1'b0;
  localparam logic ROT_IDLE_LEVEL = 1'b1;

  // Quadrature latch state: bit 1 is q1, bit 0 is q2.
  typedef enum logic [1:0] {
    QS_LOW_CCW  = 2'b00,
    QS_LOW_CW   = 2'b01,
    QS_HIGH_CCW = 2'b10,
    QS_HIGH_CW  = 2'b11
  } quad_state_e;

  localparam quad_state_e QS_RESET = QS_HIGH_CCW;

  function automatic int deb_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rot_debounce.sv
// rtl/rot_debounce.sv - single-line debouncer: output follows input only after DEBOUNCE_CYCLES stable samples
module rot_debounce
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic deb_out
);

  localparam int CNT_W = deb_cnt_width(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // The edge that would bring cnt to DEBOUNCE_CYCLES commits the new level instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      deb_out <= ROT_IDLE_LEVEL;
    end else if (sync_in == deb_out) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt     <= '0;
      deb_out <= sync_in;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rotary_quadrature_decoder.sv
// rtl/rotary_quadrature_decoder.sv - sync, debounce and quadrature-decode a rotary encoder into detent events
// Optional signed position counter rot_count is built when ROT_COUNT_EN is defined.
module rotary_quadrature_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ROT_A,
  input  logic               ROT_B,
  output logic               rotation_event,
  output logic               rotation_dir
`ifdef ROT_COUNT_EN
  ,
  output logic [COUNT_W-1:0] rot_count
`endif
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || COUNT_W < 1) begin : g_param_check
    $error("rotary_quadrature_decoder: illegal DEBOUNCE_CYCLES or COUNT_W");
  end

  logic [1:0]  a_sync;
  logic [1:0]  b_sync;
  logic        a_s;
  logic        b_s;
  logic        a_d;
  logic        b_d;
  quad_state_e state;
  quad_state_e state_next;
  logic        q1;
  logic        q2;
  logic        q1_next;
  logic        q2_next;
  logic        q1_d;
  logic        q1_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= {2{ROT_IDLE_LEVEL}};
      b_sync <= {2{ROT_IDLE_LEVEL}};
    end else begin
      a_sync <= {a_sync[0], ROT_A};
      b_sync <= {b_sync[0], ROT_B};
    end
  end

  assign a_s = a_sync[1];
  assign b_s = b_sync[1];

  rot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk    (clk),
    .rst    (rst),
    .sync_in(a_s),
    .deb_out(a_d)
  );

  rot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk    (clk),
    .rst    (rst),
    .sync_in(b_s),
    .deb_out(b_d)
  );

  assign q1 = state[1];
  assign q2 = state[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= QS_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Both-high/both-low latch q1; the mixed pairs latch q2, which records direction of approach.
  always_comb begin
    q1_next = q1;
    q2_next = q2;
    case ({a_d, b_d})
      2'b11: q1_next = 1'b1;
      2'b00: q1_next = 1'b0;
      2'b10: q2_next = 1'b1;
      2'b01: q2_next = 1'b0;
      default: begin
        q1_next = q1;
        q2_next = q2;
      end
    endcase
    state_next = quad_state_e'({q1_next, q2_next});
  end

  assign q1_rise = q1 & ~q1_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_d           <= 1'b1;
      rotation_event <= 1'b0;
      rotation_dir   <= DIR_CCW;
    end else begin
      q1_d           <= q1;
      rotation_event <= q1_rise;
      if (q1_rise) begin
        rotation_dir <= q2;
      end
    end
  end

`ifdef ROT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_count <= '0;
    end else if (q1_rise) begin
      if (q2 == DIR_CW) begin
        rot_count <= rot_count + COUNT_W'(1);
      end else begin
        rot_count <= rot_count - COUNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rotary_quadrature_decoder.sv
// tb/tb_rotary_quadrature_decoder.sv - scoreboard bench for rotary_quadrature_decoder (DEBOUNCE_CYCLES=4, COUNT_W=8)
module tb_rotary_quadrature_decoder;

  localparam int DEB = 4;
  localparam int LAT = DEB + 4;

  logic clk = 1'b0;
  logic rst;
  logic rot_a;
  logic rot_b;
  logic rotation_event;
  logic rotation_dir;
`ifdef ROT_COUNT_EN
  logic [7:0] rot_count;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dir;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  exp_t       drv_e;
  logic [7:0] model_cnt;
  logic       hold_dir;
  logic       prev_ev;

  rotary_quadrature_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .COUNT_W        (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ROT_A         (rot_a),
    .ROT_B         (rot_b),
    .rotation_event(rotation_event),
    .rotation_dir  (rotation_dir)
`ifdef ROT_COUNT_EN
    ,
    .rot_count     (rot_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed event; between events dir must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_ev  = 1'b0;
      hold_dir = 1'b0;
    end else begin
      if (rotation_event === 1'b1) begin
        chk("event_width", {31'd0, prev_ev}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_event", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("event_dir", {31'd0, rotation_dir}, {31'd0, mon_e.dir});
          chk("event_latency", cyc, mon_e.cyc);
`ifdef ROT_COUNT_EN
          chk("event_count", {24'd0, rot_count}, {24'd0, mon_e.cnt});
`endif
          hold_dir = mon_e.dir;
        end
      end else begin
        chk("dir_hold", {31'd0, rotation_dir}, {31'd0, hold_dir});
      end
      prev_ev = rotation_event;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ab(input logic a, input logic b);
    rot_a = a;
    rot_b = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_ab(1'b1, 1'b1);
    tick(3);
    rst = 1'b0;
    sb.delete();
    model_cnt = 8'd0;
    tick(2);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
    chk("event_missing", sb.size(), 32'd0);
    sb.delete();
  endtask

  // One full detent; the expectation is queued at the instant of the final raw edge.
  task automatic detent(input logic cw, input logic push);
    if (cw) set_ab(1'b0, 1'b1);
    else    set_ab(1'b1, 1'b0);
    tick(10);
    set_ab(1'b0, 1'b0);
    tick(10);
    if (cw) set_ab(1'b1, 1'b0);
    else    set_ab(1'b0, 1'b1);
    tick(10);
    if (push) begin
      model_cnt = cw ? model_cnt + 8'd1 : model_cnt - 8'd1;
      drv_e.dir = cw;
      drv_e.cnt = model_cnt;
      drv_e.cyc = cyc + LAT;
      sb.push_back(drv_e);
    end
    set_ab(1'b1, 1'b1);
    if (push) drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst       = 1'b1;
    rot_a     = 1'b1;
    rot_b     = 1'b1;
    model_cnt = 8'd0;
    hold_dir  = 1'b0;
    prev_ev   = 1'b0;

    // Reset idle
    do_reset();
    chk("reset_event", {31'd0, rotation_event}, 32'd0);
    chk("reset_dir", {31'd0, rotation_dir}, 32'd0);
    chk("reset_a_d", {31'd0, dut.a_d}, 32'd1);
    chk("reset_b_d", {31'd0, dut.b_d}, 32'd1);
`ifdef ROT_COUNT_EN
    chk("reset_count", {24'd0, rot_count}, 32'd0);
`endif
    tick(50);
    chk("idle_event", {31'd0, rotation_event}, 32'd0);

    // Clockwise detent
    detent(1'b1, 1'b1);
    chk("cw_dir", {31'd0, rotation_dir}, 32'd1);
`ifdef ROT_COUNT_EN
    chk("cw_count", {24'd0, rot_count}, 32'd1);
`endif

    // Counter-clockwise detent from reset
    do_reset();
    detent(1'b0, 1'b1);
    chk("ccw_dir", {31'd0, rotation_dir}, 32'd0);
`ifdef ROT_COUNT_EN
    chk("ccw_count", {24'd0, rot_count}, 32'h0000_00FF);
`endif

    // Bounce rejection
    do_reset();
    for (int p = 0; p < 5; p++) begin
      rot_a = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce_a_d_low", {31'd0, dut.a_d}, 32'd1);
      end
      rot_a = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce_a_d_high", {31'd0, dut.a_d}, 32'd1);
      end
    end
    tick(12);
    chk("bounce_a_d_final", {31'd0, dut.a_d}, 32'd1);

    // Count wrap: 128 clockwise, then 128 counter-clockwise
    do_reset();
    for (int i = 0; i < 128; i++) begin
      detent(1'b1, 1'b1);
`ifdef ROT_COUNT_EN
      if (i == 126) chk("wrap_127", {24'd0, rot_count}, 32'd127);
`endif
    end
`ifdef ROT_COUNT_EN
    chk("wrap_neg128", {24'd0, rot_count}, 32'h0000_0080);
`endif
    for (int i = 0; i < 128; i++) detent(1'b0, 1'b1);
`ifdef ROT_COUNT_EN
    chk("wrap_back_zero", {24'd0, rot_count}, 32'd0);
`endif

    // Reset mid-debounce
    do_reset();
    rot_a = 1'b0;
    tick(2);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_event", {31'd0, rotation_event}, 32'd0);
    chk("midrst_a_d", {31'd0, dut.a_d}, 32'd1);
    rot_a = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    chk("midrst_after_a_d", {31'd0, dut.a_d}, 32'd1);
`ifdef ROT_COUNT_EN
    chk("midrst_count", {24'd0, rot_count}, 32'd0);
`endif

    // Reset landing on the very cycle an event is high
    detent(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rotation_event === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("event_before_reset", {31'd0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_kills_event", {31'd0, rotation_event}, 32'd0);
    chk("reset_kills_dir", {31'd0, rotation_dir}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(30);
`ifdef ROT_COUNT_EN
    chk("post_reset_count", {24'd0, rot_count}, 32'd0);
`endif
    chk("post_reset_event", {31'd0, rotation_event}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
